fc_fifo: RTL and testbench
==========================

Name: fc_fifo

Overview:
- Synchronous first-word-fall-through (FWFT) FIFO that sits between consecutive fc_layer instances, and between the input/output adapters and the layer chain.
- Producer side: a layer drives wen_i and data_i, and respects full_o.
- Consumer side: a layer watches empty_o, samples data_o, and pulses ren_i.
- Provides the FIFO end of the layer interface: the status flags and data the layer consumes.

Parameters:
- WORD_SIZE, 16, data width in bits; matches the layer WORD_SIZE.
- DEPTH, 8, number of entries; must be a power of two and ≥2; elaborate-time assertion otherwise.
- AW, $clog2(DEPTH), derived pointer index width; not overridden.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- data_i  input  WORD_SIZE  write data from the producer layer.
- wen_i  input  1  write request.
- full_o  output  1  high when DEPTH entries are stored.
- data_o  output  WORD_SIZE  head-of-queue word (FWFT).
- ren_i  input  1  read request; pops the head.
- empty_o  output  1  high when no entries are stored.

Behaviour:
- Reset: asynchronous assertion, synchronous deassertion handled externally. While reset_n_i=0:
  - wr_ptr=0, rd_ptr=0
  - empty_o=1, full_o=0, data_o=0
  - storage contents need not be cleared
- Pointers: AW+1 bits wide; the MSB is the wrap bit.
  - empty_o = (wr_ptr == rd_ptr)
  - full_o = index bits equal AND wrap bits differ
  - Both flags are derived combinationally from registered pointers, so they are glitch-free relative to clk_i.
- Write accept: wen_i && !full_o. On accept, mem[wr_ptr[AW-1:0]] <= data_i and wr_ptr increments, wrapping naturally at 2^(AW+1).
- Read accept: ren_i && !empty_o. On accept, rd_ptr increments.
- data_o is mem[rd_ptr[AW-1:0]] when !empty_o, else 0.
  - The consumer samples data_o in the same cycle it asserts ren_i.
- Latency:
  - A word written at edge N is visible on data_o with empty_o=0 after edge N (one cycle write-to-read).
  - The next word appears the cycle after a pop.
- Boundary conditions:
  - Write while full: ignored. No pointer change, no storage change, data is lost silently; producers must gate on full_o.
  - Read while empty: ignored; rd_ptr unchanged.
  - Simultaneous write and read, neither full nor empty: both accepted, occupancy unchanged.
  - Simultaneous write and read while empty: write accepted, read ignored. After the edge, occupancy=1.
  - Simultaneous write and read while full: read accepted, write rejected (no pass-through). After the edge, occupancy=DEPTH-1.
  - Wrap-around: indices wrap modulo DEPTH. Flags must be correct across at least 3 full wraps.
  - Reset mid-operation: all contents are discarded immediately (empty_o=1 asynchronously); no partial transfer completes.
- No X propagation on data_o when empty.

Optional Feature:
- Macro: FC_FIFO_COUNT_EN.
- Defined: adds output port count_o, AW+1 bits wide, equal to wr_ptr - rd_ptr (modulo 2^(AW+1)).
  - Range 0..DEPTH.
  - Reset 0.
  - Updates on the same edge as the pointers.
  - Used for layer debug/occupancy monitoring.
- Undefined: the port is absent and there is no count logic; all other behaviour is identical.

Decomposition:
- Shared package fc_pkg:
  - typedef word_t (logic [WORD_SIZE-1:0])
  - default WORD_SIZE and FIFO DEPTH localparams, shared with fc_layer
- One sub-module: fc_fifo_mem, a DEPTH×WORD_SIZE register file.
  - One synchronous write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
  - No reset.
- fc_fifo holds the pointers, flags, accept logic and optional count.

Test Plan:
- Reset then idle:
  - Assert reset_n_i=0 mid-cycle → empty_o=1, full_o=0, data_o=0 immediately.
  - Release → flags hold.
- Single word:
  - Write 0x1234 at edge 1 → after edge 1, empty_o=0, data_o=0x1234.
  - ren_i at edge 2 → empty_o=1, data_o=0.
- Fill to full (DEPTH=8):
  - Write 0x0001..0x0008 → full_o=1 after the 8th edge.
  - Write 0x0009 → rejected.
  - Drain 8 → data_o sequence 0x0001..0x0008, then empty_o=1.
- Simultaneous operations:
  - Empty, wen+ren with 0xAAAA → occupancy 1, data_o=0xAAAA.
  - Full, wen+ren → occupancy 7; the rejected word never appears.
  - Half full, wen+ren for 20 cycles → full_o/empty_o stay 0 and order is preserved.
- Wrap and reset:
  - Stream 30 words with random wen/ren gaps against a scoreboard → in-order, no loss or duplication.
  - Assert reset with 5 entries → empty_o=1; words written after release start fresh.
- With FC_FIFO_COUNT_EN:
  - count_o tracks 0→8→0 through the fill/drain test.
  - count_o stays 8 on a rejected write.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer chain: default word width,
// default inter-layer FIFO depth and the word type.
package fc_pkg;

    localparam int FC_WORD_SIZE  = 16;
    localparam int FC_FIFO_DEPTH = 8;

    typedef logic [FC_WORD_SIZE-1:0] word_t;

endpackage : fc_pkg

// File: rtl/fc_fifo_mem.sv
// DEPTH x WORD_SIZE register file: one synchronous write port, one
// asynchronous read port, no reset on the storage.
module fc_fifo_mem
    import fc_pkg::*;
#(
    parameter int WORD_SIZE = FC_WORD_SIZE,
    parameter int DEPTH     = FC_FIFO_DEPTH,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic [WORD_SIZE-1:0] rdata
);

    logic [WORD_SIZE-1:0] mem_r [DEPTH];

    // Storage write on the rising edge
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule : fc_fifo_mem

// File: rtl/fc_fifo.sv
// First-word-fall-through FIFO between fc_layer stages. Defining
// FC_FIFO_COUNT_EN adds the count_o occupancy output.
module fc_fifo
    import fc_pkg::*;
#(
    parameter int WORD_SIZE = FC_WORD_SIZE,
    parameter int DEPTH     = FC_FIFO_DEPTH,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [WORD_SIZE-1:0] data_i,
    input  logic                 wen_i,
    output logic                 full_o,
    output logic [WORD_SIZE-1:0] data_o,
    input  logic                 ren_i,
    output logic                 empty_o
`ifdef FC_FIFO_COUNT_EN
    ,
    output logic [AW:0]          count_o
`endif
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("fc_fifo: DEPTH must be a power of two and at least 2");
    end

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    logic [AW:0]          wr_ptr_r;
    logic [AW:0]          rd_ptr_r;
    logic                 empty_s;
    logic                 full_s;
    logic                 wr_acc_s;
    logic                 rd_acc_s;
    logic [WORD_SIZE-1:0] rdata_s;

    assign empty_s  = (wr_ptr_r == rd_ptr_r);
    assign full_s   = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) &&
                      (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign wr_acc_s = wen_i && !full_s;
    assign rd_acc_s = ren_i && !empty_s;

    // Pointer registers advance on accepted transfers only
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    fc_fifo_mem #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_mem (
        .clk   (clk_i),
        .we    (wr_acc_s),
        .waddr (wr_ptr_r[AW-1:0]),
        .wdata (data_i),
        .raddr (rd_ptr_r[AW-1:0]),
        .rdata (rdata_s)
    );

    // Head word is forced to zero when empty so stale or unwritten storage never leaks
    always_comb begin
        data_o = {WORD_SIZE{1'b0}};
        if (empty_s) begin
            data_o = {WORD_SIZE{1'b0}};
        end else begin
            data_o = rdata_s;
        end
    end

    assign empty_o = empty_s;
    assign full_o  = full_s;

`ifdef FC_FIFO_COUNT_EN
    logic [AW:0] count_r;

    // Occupancy tracks the pointer difference, updated on the same edge
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r <= {(AW+1){1'b0}};
        end else begin
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign count_o = count_r;
`endif

endmodule : fc_fifo

// File: tb/tb_fc_fifo.sv
// Directed self-checking bench for fc_fifo (DEPTH=8, WORD_SIZE=16), plus a
// randomised-gap stream against a queue scoreboard.
module tb_fc_fifo;

    logic        clk_i;
    logic        reset_n_i;
    logic [15:0] data_i;
    logic        wen_i;
    logic        full_o;
    logic [15:0] data_o;
    logic        ren_i;
    logic        empty_o;
`ifdef FC_FIFO_COUNT_EN
    logic [3:0]  count_o;
`endif

    int n_checks;
    int n_fail;

    fc_fifo #(
        .WORD_SIZE (16),
        .DEPTH     (8)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (data_i),
        .wen_i     (wen_i),
        .full_o    (full_o),
        .data_o    (data_o),
        .ren_i     (ren_i),
        .empty_o   (empty_o)
`ifdef FC_FIFO_COUNT_EN
        ,
        .count_o   (count_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_count(input string tag, input int exp);
`ifdef FC_FIFO_COUNT_EN
        check_eq(tag, 32'(count_o), 32'(exp));
`endif
    endtask

    task automatic push(input logic [15:0] w);
        data_i = w;
        wen_i  = 1'b1;
        tick();
        wen_i  = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [15:0] w);
        check_eq(tag, 32'(data_o), 32'(w));
        ren_i = 1'b1;
        tick();
        ren_i = 1'b0;
    endtask

    logic [15:0] q[$];
    int          sent;
    int          rcvd;
    int          cyc;
    logic        do_w;
    logic        do_r;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset_n_i = 1'b0;
        wen_i     = 1'b0;
        ren_i     = 1'b0;
        data_i    = 16'h0000;

        // Reset then idle
        #3;
        check_eq("rst_empty", 32'(empty_o), 32'd1);
        check_eq("rst_full", 32'(full_o), 32'd0);
        check_eq("rst_data", 32'(data_o), 32'd0);
        check_count("rst_count", 0);
        tick();
        tick();
        reset_n_i = 1'b1;
        tick();
        check_eq("idle_empty", 32'(empty_o), 32'd1);
        check_eq("idle_full", 32'(full_o), 32'd0);

        // Single word
        push(16'h1234);
        check_eq("single_empty", 32'(empty_o), 32'd0);
        check_eq("single_data", 32'(data_o), 32'h1234);
        check_count("single_count", 1);
        ren_i = 1'b1;
        tick();
        ren_i = 1'b0;
        check_eq("single_pop_empty", 32'(empty_o), 32'd1);
        check_eq("single_pop_data", 32'(data_o), 32'd0);

        // Fill to full, rejected write, drain
        for (int i = 1; i <= 8; i++) begin
            check_eq("fill_notfull", 32'(full_o), 32'd0);
            push(16'(i));
        end
        check_eq("fill_full", 32'(full_o), 32'd1);
        check_eq("fill_head", 32'(data_o), 32'h0001);
        check_count("fill_count", 8);
        push(16'h0009);
        check_eq("rej_full", 32'(full_o), 32'd1);
        check_eq("rej_head", 32'(data_o), 32'h0001);
        check_count("rej_count", 8);
        for (int i = 1; i <= 8; i++) begin
            pop_expect("drain_data", 16'(i));
        end
        check_eq("drain_empty", 32'(empty_o), 32'd1);
        check_eq("drain_data0", 32'(data_o), 32'd0);
        check_count("drain_count", 0);

        // Read while empty is ignored
        ren_i = 1'b1;
        tick();
        ren_i = 1'b0;
        check_eq("rd_empty_ign", 32'(empty_o), 32'd1);

        // Simultaneous write and read while empty
        data_i = 16'hAAAA;
        wen_i  = 1'b1;
        ren_i  = 1'b1;
        tick();
        wen_i  = 1'b0;
        ren_i  = 1'b0;
        check_eq("wr_rd_empty_empty", 32'(empty_o), 32'd0);
        check_eq("wr_rd_empty_data", 32'(data_o), 32'hAAAA);
        check_count("wr_rd_empty_count", 1);
        pop_expect("wr_rd_empty_pop", 16'hAAAA);
        check_eq("wr_rd_empty_occ1", 32'(empty_o), 32'd1);

        // Simultaneous write and read while full
        for (int i = 0; i < 8; i++) push(16'h0010 + 16'(i));
        check_eq("wr_rd_full_pre", 32'(full_o), 32'd1);
        data_i = 16'hDEAD;
        wen_i  = 1'b1;
        ren_i  = 1'b1;
        tick();
        wen_i  = 1'b0;
        ren_i  = 1'b0;
        check_eq("wr_rd_full_full", 32'(full_o), 32'd0);
        check_count("wr_rd_full_count", 7);
        for (int i = 1; i < 8; i++) pop_expect("wr_rd_full_data", 16'h0010 + 16'(i));
        check_eq("wr_rd_full_empty", 32'(empty_o), 32'd1);

        // Half full, 20 cycles of concurrent write and read
        for (int i = 0; i < 4; i++) push(16'h0020 + 16'(i));
        for (int i = 0; i < 20; i++) begin
            check_eq("half_head", 32'(data_o), 32'h0020 + 32'(i));
            data_i = 16'h0024 + 16'(i);
            wen_i  = 1'b1;
            ren_i  = 1'b1;
            tick();
            check_eq("half_full", 32'(full_o), 32'd0);
            check_eq("half_empty", 32'(empty_o), 32'd0);
        end
        wen_i = 1'b0;
        ren_i = 1'b0;
        check_count("half_count", 4);
        for (int i = 0; i < 4; i++) pop_expect("half_tail", 16'h0034 + 16'(i));
        check_eq("half_done", 32'(empty_o), 32'd1);

        // Random-gap stream against a scoreboard
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while ((sent < 30 || q.size() > 0) && cyc < 1000) begin
            check_eq("sb_empty", 32'(empty_o), 32'(q.size() == 0));
            check_eq("sb_full", 32'(full_o), 32'(q.size() == 8));
            do_w = (sent < 30) && (q.size() < 8) && ($urandom_range(0, 1) == 1);
            do_r = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            if (do_r) check_eq("sb_data", 32'(data_o), 32'(q[0]));
            data_i = 16'h0100 + 16'(sent);
            wen_i  = do_w;
            ren_i  = do_r;
            tick();
            if (do_r) begin
                void'(q.pop_front());
                rcvd++;
            end
            if (do_w) begin
                q.push_back(data_i);
                sent++;
            end
            cyc++;
        end
        wen_i = 1'b0;
        ren_i = 1'b0;
        check_eq("sb_rcvd", 32'(rcvd), 32'd30);
        check_eq("sb_end_empty", 32'(empty_o), 32'd1);

        // Reset with 5 entries stored
        for (int i = 0; i < 5; i++) push(16'h0050 + 16'(i));
        check_count("pre_rst_count", 5);
        #2;
        reset_n_i = 1'b0;
        #1;
        check_eq("midrst_empty", 32'(empty_o), 32'd1);
        check_eq("midrst_full", 32'(full_o), 32'd0);
        check_eq("midrst_data", 32'(data_o), 32'd0);
        check_count("midrst_count", 0);
        tick();
        reset_n_i = 1'b1;
        tick();
        check_eq("post_rst_empty", 32'(empty_o), 32'd1);
        push(16'h0077);
        check_eq("post_rst_data", 32'(data_o), 32'h0077);
        check_count("post_rst_count", 1);
        pop_expect("post_rst_pop", 16'h0077);
        check_eq("post_rst_fin", 32'(empty_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fc_fifo
